color_wheel_sequencer: RTL and testbench

Sequences the three RGB fade channels through a continuous six-segment hue wheel and drives the LED PWM pins. One channel ramps per segment while the other two hold at full or zero, so exactly one duty value moves at any time. Adds run/pause/stop control and exact step timing, and sits between the board-level enable/pause inputs and the RGB LED pins.

---
 rtl/color_wheel_pkg.sv | 52 +++++
 rtl/pwm_channel.sv | 24 ++
 rtl/color_wheel_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_color_wheel_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_wheel_pkg.sv
// Shared types for the RGB hue-wheel sequencer: FSM states, wheel segments
// and the per-segment ramp lookup.
package color_wheel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } segment_t;

  typedef enum logic [1:0] {
    RAMP_NONE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_t;

  typedef struct packed {
    ramp_t r;
    ramp_t g;
    ramp_t b;
  } ramp_action_t;

  // Exactly one channel moves per segment; the other two hold at 0 or full.
  function automatic ramp_action_t segment_action(input segment_t seg);
    ramp_action_t act;
    act = '{r: RAMP_NONE, g: RAMP_NONE, b: RAMP_NONE};
    case (seg)
      S0:      act.g = RAMP_UP;
      S1:      act.r = RAMP_DOWN;
      S2:      act.b = RAMP_UP;
      S3:      act.g = RAMP_DOWN;
      S4:      act.r = RAMP_UP;
      S5:      act.b = RAMP_DOWN;
      default: act = '{r: RAMP_NONE, g: RAMP_NONE, b: RAMP_NONE};
    endcase
    return act;
  endfunction

  function automatic segment_t next_segment(input segment_t seg);
    return (seg == S5) ? S0 : segment_t'(seg + 3'd1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED pin: registered compare of the shared PWM counter against a duty,
// gated off while the sequencer is idle.
module pwm_channel
  import color_wheel_pkg::*;
#(
  parameter int DUTY_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] pwm_count,
  input  logic [DUTY_W-1:0] duty,
  input  logic              en,
  output logic              pwm
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en && (pwm_count < duty);
    end
  end

endmodule

// File: rtl/color_wheel_sequencer.sv
// Steps the RGB duties around a six-segment hue wheel under enable/pause
// control and drives the three LED PWM pins.
//
// state | meaning
// IDLE  | wheel parked at the reset hue, prescaler cleared, pins low
// RUN   | prescaler counting, one fade step applied per tick
// PAUSE | prescaler and duties frozen, pins still driven from held duties
module color_wheel_sequencer
  import color_wheel_pkg::*;
#(
  parameter  int STEP_INTERVAL = 12000,
  parameter  int STEP_MAX      = 166,
  parameter  int PWM_INTERVAL  = 1200,
  parameter  int STEP_SIZE     = PWM_INTERVAL / STEP_MAX,
  localparam int FULL          = STEP_MAX * STEP_SIZE,
  localparam int DUTY_W        = $clog2(PWM_INTERVAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pause,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic [2:0]        segment,
  output logic              step_tick
);

  localparam int PRE_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int STEP_W = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_INTERVAL - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST  = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(FULL);
  localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(STEP_SIZE);

  state_t              state_q, state_nxt;
  logic [PRE_W-1:0]    pre_q, pre_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  segment_t            seg_q, seg_nxt;
  logic [DUTY_W-1:0]   duty_r_q, duty_r_nxt;
  logic [DUTY_W-1:0]   duty_g_q, duty_g_nxt;
  logic [DUTY_W-1:0]   duty_b_q, duty_b_nxt;
  logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_nxt;
  logic                tick_q, tick_nxt;
  logic                step_fire;
  logic                going_idle;
  ramp_action_t        act;

  // Saturating ramp; FULL is a whole number of steps so segment ends land exactly.
  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] duty,
                                             input ramp_t dir);
    logic [DUTY_W-1:0] res;
    res = duty;
    case (dir)
      RAMP_UP:   res = (duty >= DUTY_FULL - DUTY_STEP) ? DUTY_FULL : duty + DUTY_STEP;
      RAMP_DOWN: res = (duty <= DUTY_STEP) ? '0 : duty - DUTY_STEP;
      default:   res = duty;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)    state_nxt = IDLE;
        else if (pause) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (!enable)     state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A tick seen in RUN is applied even if pause rises in the same cycle;
  // only dropping enable discards it.
  assign step_fire  = (state_q == RUN) && (pre_q == PRE_LAST);
  assign going_idle = (state_nxt == IDLE);

  always_comb begin
    act        = segment_action(seg_q);
    pre_nxt    = pre_q;
    step_nxt   = step_q;
    seg_nxt    = seg_q;
    duty_r_nxt = duty_r_q;
    duty_g_nxt = duty_g_q;
    duty_b_nxt = duty_b_q;
    tick_nxt   = 1'b0;
    if (going_idle) begin
      pre_nxt    = '0;
      step_nxt   = '0;
      seg_nxt    = S0;
      duty_r_nxt = DUTY_FULL;
      duty_g_nxt = '0;
      duty_b_nxt = '0;
    end else if (state_q == RUN) begin
      if (step_fire) begin
        pre_nxt    = '0;
        tick_nxt   = 1'b1;
        duty_r_nxt = ramp(duty_r_q, act.r);
        duty_g_nxt = ramp(duty_g_q, act.g);
        duty_b_nxt = ramp(duty_b_q, act.b);
        if (step_q == STEP_LAST) begin
          step_nxt = '0;
          seg_nxt  = next_segment(seg_q);
        end else begin
          step_nxt = step_q + 1'b1;
        end
      end else begin
        pre_nxt = pre_q + 1'b1;
      end
    end
  end

  assign pwm_cnt_nxt = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      step_q    <= '0;
      seg_q     <= S0;
      duty_r_q  <= DUTY_FULL;
      duty_g_q  <= '0;
      duty_b_q  <= '0;
      pwm_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_q     <= pre_nxt;
      step_q    <= step_nxt;
      seg_q     <= seg_nxt;
      duty_r_q  <= duty_r_nxt;
      duty_g_q  <= duty_g_nxt;
      duty_b_q  <= duty_b_nxt;
      pwm_cnt_q <= pwm_cnt_nxt;
      tick_q    <= tick_nxt;
    end
  end

  pwm_channel #(.DUTY_W(DUTY_W)) u_pwm_r (
    .clk       (clk),
    .rst       (rst),
    .pwm_count (pwm_cnt_q),
    .duty      (duty_r_q),
    .en        (!going_idle),
    .pwm       (pwm_r)
  );

  pwm_channel #(.DUTY_W(DUTY_W)) u_pwm_g (
    .clk       (clk),
    .rst       (rst),
    .pwm_count (pwm_cnt_q),
    .duty      (duty_g_q),
    .en        (!going_idle),
    .pwm       (pwm_g)
  );

  pwm_channel #(.DUTY_W(DUTY_W)) u_pwm_b (
    .clk       (clk),
    .rst       (rst),
    .pwm_count (pwm_cnt_q),
    .duty      (duty_b_q),
    .en        (!going_idle),
    .pwm       (pwm_b)
  );

  assign duty_r    = duty_r_q;
  assign duty_g    = duty_g_q;
  assign duty_b    = duty_b_q;
  assign segment   = seg_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_color_wheel_sequencer.sv
// Bench for color_wheel_sequencer with a small wheel (4-cycle steps, 3 steps
// per segment, 12-cycle PWM); expected hues come from a closed-form model.
module tb_color_wheel_sequencer;

  localparam int SI   = 4;
  localparam int SM   = 3;
  localparam int PI   = 12;
  localparam int FULL = SM * (PI / SM);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [2:0] seg;
  } exp_t;

  localparam logic [18:0] IDLE_VEC = {4'd12, 4'd0, 4'd0, 3'd0, 4'b0000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] duty_r, duty_g, duty_b;
  logic       pwm_r, pwm_g, pwm_b;
  logic [2:0] segment;
  logic       step_tick;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k_model = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  color_wheel_sequencer #(
    .STEP_INTERVAL (SI),
    .STEP_MAX      (SM),
    .PWM_INTERVAL  (PI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pause     (pause),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .segment   (segment),
    .step_tick (step_tick)
  );

  // Hue after k ticks from the parked state, computed from segment position.
  function automatic exp_t wheel_point(input int k);
    int   s;
    int   d;
    exp_t e;
    s = (k / SM) % 6;
    d = (k % SM) * (PI / SM);
    e.seg = 3'(s);
    e.r = 4'd0;
    e.g = 4'd0;
    e.b = 4'd0;
    case (s)
      0: begin e.r = 4'(FULL);     e.g = 4'(d);        e.b = 4'd0;        end
      1: begin e.r = 4'(FULL - d); e.g = 4'(FULL);     e.b = 4'd0;        end
      2: begin e.r = 4'd0;         e.g = 4'(FULL);     e.b = 4'(d);       end
      3: begin e.r = 4'd0;         e.g = 4'(FULL - d); e.b = 4'(FULL);    end
      4: begin e.r = 4'(d);        e.g = 4'd0;         e.b = 4'(FULL);    end
      default: begin e.r = 4'(FULL); e.g = 4'd0;       e.b = 4'(FULL - d); end
    endcase
    return e;
  endfunction

  task automatic wait_tick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (step_tick !== 1'b1 && c < 40);
  endtask

  // Scoreboard producer/consumer: expected hue queued per step, popped when
  // the DUT strobes step_tick.
  task automatic drive_steps(input int n, input int first_gap, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   c;
      int   want_gap;
      k_model++;
      sb_q.push_back(wheel_point(k_model));
      want_gap = (i == 0) ? first_gap : SI;
      wait_tick(c);
      n_cmp++;
      if (c !== want_gap) begin
        n_bad++;
        $display("FAIL %s_gap k=%0d: got %0d cycles want %0d", tag, k_model, c, want_gap);
      end
      e = sb_q.pop_front();
      n_cmp++;
      if ({duty_r, duty_g, duty_b, segment} !== e) begin
        n_bad++;
        $display("FAIL %s_hue k=%0d: got r=%0d g=%0d b=%0d seg=%0d want r=%0d g=%0d b=%0d seg=%0d",
                 tag, k_model, duty_r, duty_g, duty_b, segment, e.r, e.g, e.b, e.seg);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick} !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h",
               {duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick}, IDLE_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick} !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL idle_%0d: got %h want %h", i,
                 {duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick}, IDLE_VEC);
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b1;
    drive_steps(6, SI + 1, "enable");
  endtask

  task automatic test_full_wheel();
    drive_steps(12, SI, "wheel");
    n_cmp++;
    if ({duty_r, duty_g, duty_b, segment} !== {4'd12, 4'd0, 4'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL wheel_closure: got r=%0d g=%0d b=%0d seg=%0d want 12/0/0 seg 0",
               duty_r, duty_g, duty_b, segment);
    end
  endtask

  task automatic test_pause();
    exp_t held;
    int   toggles;
    logic prev_b;
    drive_steps(7, SI, "to_s2");
    held = wheel_point(k_model);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    toggles = 0;
    prev_b = pwm_b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({duty_r, duty_g, duty_b, segment, step_tick} !== {held, 1'b0}) begin
        n_bad++;
        $display("FAIL pause_frozen_%0d: got r=%0d g=%0d b=%0d seg=%0d tick=%0b want r=%0d g=%0d b=%0d seg=%0d tick=0",
                 i, duty_r, duty_g, duty_b, segment, step_tick, held.r, held.g, held.b, held.seg);
      end
      if (pwm_b !== prev_b) toggles++;
      prev_b = pwm_b;
    end
    n_cmp++;
    if (toggles < 2) begin
      n_bad++;
      $display("FAIL pause_pwm_toggle: got %0d toggles want at least 2", toggles);
    end
    pause = 1'b0;
    drive_steps(1, 2, "resume");
  endtask

  task automatic test_pwm_shape();
    int hr, hg, hb;
    drive_steps(3, SI, "to_shape");
    pause = 1'b1;
    @(negedge clk);
    hr = 0;
    hg = 0;
    hb = 0;
    for (int i = 0; i < PI; i++) begin
      @(negedge clk);
      hr += int'(pwm_r);
      hg += int'(pwm_g);
      hb += int'(pwm_b);
    end
    n_cmp++;
    if (hr !== 0) begin
      n_bad++;
      $display("FAIL pwm_duty0: got %0d high cycles want 0", hr);
    end
    n_cmp++;
    if (hg !== 4) begin
      n_bad++;
      $display("FAIL pwm_duty4: got %0d high cycles want 4", hg);
    end
    n_cmp++;
    if (hb !== PI) begin
      n_bad++;
      $display("FAIL pwm_duty12: got %0d high cycles want %0d", hb, PI);
    end
    pause = 1'b0;
    drive_steps(1, SI, "shape_resume");
  endtask

  task automatic test_disable();
    drive_steps(16, SI, "to_s3");
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick} !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL disable_%0d: got %h want %h", i,
                 {duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick}, IDLE_VEC);
      end
    end
    k_model = 0;
    sb_q.delete();
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b1;
    drive_steps(13, SI + 1, "to_s4");
    pause = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick} !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h",
               {duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick}, IDLE_VEC);
    end
    enable = 1'b0;
    pause = 1'b0;
    k_model = 0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick} !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %h want %h",
               {duty_r, duty_g, duty_b, segment, pwm_r, pwm_g, pwm_b, step_tick}, IDLE_VEC);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    drive_steps(4, SI + 1, "restart");
  endtask

  initial begin
    test_reset();
    test_enable();
    test_full_wheel();
    test_pause();
    test_pwm_shape();
    test_disable();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
